// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared 4x4 multiplier controller.
package mult_share_pkg;

    localparam int OPW    = 4;  // operand width
    localparam int PW     = 8;  // product width
    localparam int NPORTS = 2;  // number of requesters

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/array_mult4.sv
// Purely combinational 4x4 unsigned array multiplier: AND partial products
// summed by ripple rows of full adders, one row per multiplier bit.
module array_mult4
    import mult_share_pkg::*;
(
    input  logic [OPW-1:0] m,
    input  logic [OPW-1:0] q,
    output logic [PW-1:0]  p
);

    function automatic logic [1:0] fa(input logic x, input logic y, input logic cin);
        fa = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

    // Row 0 is the bare partial product; each later row adds the next
    // partial product to the upper bits of the running sum.
    always_comb begin
        logic [OPW-1:0] upper;
        logic [OPW-1:0] row_sum;
        logic           carry;
        logic [1:0]     fa_o;
        p       = '0;
        row_sum = '0;
        carry   = 1'b0;
        fa_o    = '0;
        p[0]    = m[0] & q[0];
        upper   = {1'b0, m[OPW-1:1] & {(OPW-1){q[0]}}};
        for (int i = 1; i < OPW; i++) begin
            carry = 1'b0;
            for (int j = 0; j < OPW; j++) begin
                fa_o       = fa(m[j] & q[i], upper[j], carry);
                row_sum[j] = fa_o[0];
                carry      = fa_o[1];
            end
            p[i]  = row_sum[0];
            upper = {carry, row_sum[OPW-1:1]};
        end
        p[PW-1:OPW] = upper;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational 4x4 multiplier between two requesters with
// round-robin arbitration, a programmable settle delay and a held response.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int MULT_LAT = 1,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req_valid,
    output logic [NPORTS-1:0]     req_ready,
    input  logic [NPORTS*OPW-1:0] req_a,
    input  logic [NPORTS*OPW-1:0] req_b,
    output logic [NPORTS-1:0]     resp_valid,
    input  logic [NPORTS-1:0]     resp_ready,
    output logic [PW-1:0]         resp_p,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    if (MULT_LAT < 1 || MULT_LAT > 15) begin : g_bad_lat
        $error("mult_share_ctrl: MULT_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_INIT = 4'(MULT_LAT - 1);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [3:0]       lat_q, lat_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant;
    logic [OPW-1:0]   sel_a;
    logic [OPW-1:0]   sel_b;
    logic [PW-1:0]    mult_p;

    // Multiplier sees only the registered operands, never the live ports.
    array_mult4 u_mult (
        .m (a_q),
        .q (b_q),
        .p (mult_p)
    );

    // Arbitration: a lone requester wins, contention is settled by rr_q.
    always_comb begin
        grant = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            grant = rr_q;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
        sel_a     = grant ? req_a[OPW +: OPW] : req_a[0 +: OPW];
        sel_b     = grant ? req_b[OPW +: OPW] : req_b[0 +: OPW];
        req_ready = '0;
        if (state_q == IDLE && (|req_valid) && !rst) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Next-state logic: accept in IDLE, count down the settle delay, hold the result.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        lat_d   = lat_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|(req_valid & req_ready)) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    owner_d = grant;
                    rr_d    = ~grant;
                    lat_d   = LAT_INIT;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (lat_q == 4'd0) begin
                    p_d     = mult_p;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response presentation: only the owner's valid is raised, product zeroed otherwise.
    always_comb begin
        resp_valid = '0;
        resp_p     = '0;
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
            resp_p              = p_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign op_count = cnt_q;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            lat_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares each completed response.
module tb_mult_share_ctrl;

    localparam int LAT = 1;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [7:0]    req_a;
    logic [7:0]    req_b;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready;
    logic [7:0]    resp_p;
    logic          busy;
    logic [CW-1:0] op_count;

    typedef struct {
        logic [1:0] port;
        logic [7:0] p;
    } exp_t;

    exp_t          expq[$];
    int            checks = 0;
    int            errors = 0;
    int            resp_seen = 0;
    logic [CW-1:0] mdl_cnt = '0;

    mult_share_ctrl #(.MULT_LAT(LAT), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_p     (resp_p),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [1:0] port, input int a, input int b);
        exp_t e;
        e.port = port;
        e.p    = 8'(a * b);
        expq.push_back(e);
    endfunction

    // Monitor: invariant checks every cycle, scoreboard pop on each completed response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mdl_cnt = '0;
        end else begin
            check("op_count", 32'(op_count), 32'(mdl_cnt));
            check("req_ready_not_both", {31'b0, req_ready == 2'b11}, 32'd0);
            if (resp_valid == 2'b00) begin
                check("resp_p_zero_when_idle", 32'(resp_p), 32'd0);
            end else begin
                check("resp_valid_onehot", {31'b0, $onehot(resp_valid)}, 32'd1);
                check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if ((resp_valid & resp_ready) != 2'b00) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got port %b product %0h expected none", resp_valid, resp_p);
                    end else begin
                        e = expq.pop_front();
                        check("resp_port", 32'(resp_valid), 32'(e.port));
                        check("resp_p", 32'(resp_p), 32'(e.p));
                    end
                    mdl_cnt = mdl_cnt + 1'b1;
                    resp_seen++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a      = 8'h00;
        req_b      = 8'h00;
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait (bounded) for a negedge where some req_ready bit is high.
    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got req_ready %b expected a grant", name, req_ready);
        end
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        @(negedge clk);
        while (resp_valid == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got resp_valid %b expected a response", name, resp_valid);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, expq.size());
            expq.delete();
        end
        tick();
    endtask

    initial begin
        logic [3:0] a4;
        logic [3:0] b4;
        logic [1:0] pm;
        int         seen0;

        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a      = 8'h00;
        req_b      = 8'h00;
        #3;
        // Reset state, with requests present to show req_ready stays low.
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_p", 32'(resp_p), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        do_reset();

        // Single port 0 request, 15x15, latency and completion.
        resp_ready = 2'b11;
        req_valid  = 2'b01;
        req_a      = 8'h0F;
        req_b      = 8'h0F;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'h1);
        check("t1_busy_idle", 32'(busy), 32'd0);
        push(2'b01, 15, 15);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_mult_no_resp", 32'(resp_valid), 32'd0);
        check("t1_busy_mult", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_latency_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_p", 32'(resp_p), 32'hE1);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_op_count", 32'(op_count), 32'd1);
        tick();

        // Contention from reset: p0 3x5 and p1 7x9, alternating grants.
        do_reset();
        resp_ready = 2'b11;
        req_a      = {4'd7, 4'd3};
        req_b      = {4'd9, 4'd5};
        req_valid  = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ready("t2_grant");
            pm = (g % 2 == 0) ? 2'b01 : 2'b10;
            check("t2_grant_order", 32'(req_ready), 32'(pm));
            if (pm == 2'b01) push(2'b01, 3, 5);
            else             push(2'b10, 7, 9);
            tick();
        end
        req_valid = 2'b00;
        drain("t2");

        // Backpressure on p1 12x10; non-owner resp_ready must be ignored.
        resp_ready = 2'b00;
        req_a      = {4'd12, 4'd0};
        req_b      = {4'd10, 4'd0};
        req_valid  = 2'b10;
        wait_ready("t3_grant");
        check("t3_req_ready", 32'(req_ready), 32'h2);
        push(2'b10, 12, 10);
        tick();
        req_valid  = 2'b00;
        resp_ready = 2'b01;
        wait_resp("t3_resp");
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", 32'(resp_valid), 32'h2);
            check("t3_hold_p", 32'(resp_p), 32'h78);
            check("t3_hold_req_ready", 32'(req_ready), 32'd0);
            if (c < 4) @(negedge clk);
        end
        tick();
        resp_ready = 2'b10;
        drain("t3");

        // Operands change right after acceptance; product must use latched values.
        resp_ready = 2'b11;
        req_a      = {4'd0, 4'd4};
        req_b      = {4'd0, 4'd6};
        req_valid  = 2'b01;
        wait_ready("t4_grant");
        push(2'b01, 4, 6);
        tick();
        req_valid = 2'b00;
        req_a     = {4'd0, 4'd15};
        req_b     = {4'd0, 4'd15};
        drain("t4");

        // Reset pulsed while MULT is in flight.
        req_a     = {4'd0, 4'd9};
        req_b     = {4'd0, 4'd9};
        req_valid = 2'b01;
        wait_ready("t5_grant");
        @(posedge clk);
        #2;
        check("t5_busy_in_mult", 32'(busy), 32'd1);
        rst       = 1'b1;
        expq.delete();
        req_valid = 2'b11;
        #1;
        check("t5_rst_req_ready", 32'(req_ready), 32'd0);
        check("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_rst_resp_p", 32'(resp_p), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_op_count", 32'(op_count), 32'd0);
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_no_resp", 32'(resp_valid), 32'd0);
        end
        tick();
        req_a     = {4'd2, 4'd3};
        req_b     = {4'd4, 4'd5};
        req_valid = 2'b11;
        wait_ready("t5_grant2");
        check("t5_first_grant_p0", 32'(req_ready), 32'h1);
        push(2'b01, 3, 5);
        tick();
        req_valid = 2'b00;
        drain("t5");

        // Sweep all 256 operand pairs back to back; op_count wraps to 0.
        do_reset();
        resp_ready = 2'b11;
        seen0      = resp_seen;
        for (int i = 0; i < 256; i++) begin
            a4 = 4'(i >> 4);
            b4 = 4'(i);
            pm = (i % 2 == 0) ? 2'b01 : 2'b10;
            req_a     = (pm == 2'b01) ? {4'd0, a4} : {a4, 4'd0};
            req_b     = (pm == 2'b01) ? {4'd0, b4} : {b4, 4'd0};
            req_valid = pm;
            wait_ready("t6_grant");
            check("t6_grant", 32'(req_ready), 32'(pm));
            push(pm, int'(a4), int'(b4));
            tick();
        end
        req_valid = 2'b00;
        drain("t6");
        @(negedge clk);
        check("t6_resp_total", 32'(resp_seen - seen0), 32'd256);
        check("t6_op_count_wrap", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
